// File: rtl/mdc_in_frontend_pkg.sv
// Shared widths, mode codes and enums for the MDC input front end.
// Optional error counting is enabled with MDC_FE_ERRCNT_EN.
package mdc_pkg;

   localparam int N_WORDS = 16;
   localparam int CW_W    = 15;
   localparam int MW_W    = 9;
   localparam int DW      = 11;
   localparam int MD_W    = 5;
   localparam int CNT_W   = $clog2(N_WORDS);
   localparam int EC_W    = 5;

   localparam logic [MD_W-1:0] MODE_2X2 = 5'b00100;
   localparam logic [MD_W-1:0] MODE_3X3 = 5'b00110;
   localparam logic [MD_W-1:0] MODE_4X4 = 5'b10110;

   typedef enum logic [1:0] {
      SZ_ILL = 2'b00,
      SZ_2X2 = 2'b01,
      SZ_3X3 = 2'b10,
      SZ_4X4 = 2'b11
   } frm_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } fe_state_t;

   function automatic frm_size_t mode_to_size(
      input logic [MD_W-1:0] m
   );
      frm_size_t s;
      s = SZ_ILL;
      case (m)
         MODE_2X2: s = SZ_2X2;
         MODE_3X3: s = SZ_3X3;
         MODE_4X4: s = SZ_4X4;
         default:  s = SZ_ILL;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mdc_in_frontend_if.sv
// Burst input and frame handshake bundle of the MDC input front end.
// Used by mdc_in_frontend in all builds, with or without MDC_FE_ERRCNT_EN.
interface mdc_in_frontend_if;
   import mdc_pkg::*;

   logic                    in_valid;
   logic [CW_W-1:0]         in_data;
   logic [MW_W-1:0]         in_mode;
   logic                    frm_valid;
   logic                    frm_ready;
   logic [N_WORDS*DW-1:0]   frm_data;
   logic [1:0]              frm_size;
   logic [EC_W-1:0]         err_cnt;
   logic                    ovf;

   modport master (
      output in_valid, in_data, in_mode, frm_ready,
      input  frm_valid, frm_data, frm_size, err_cnt, ovf
   );

   modport slave (
      input  in_valid, in_data, in_mode, frm_ready,
      output frm_valid, frm_data, frm_size, err_cnt, ovf
   );

endinterface

// File: rtl/mdc_in_frontend_hamming_dec.sv
// Single-error-correcting Hamming decoder; cw[CW-1] is position 1.
// Shared by data and mode paths; independent of MDC_FE_ERRCNT_EN.
module mdc_hamming_dec #(
   parameter int CW = 15,
   parameter int DW = 11
) (
   input  logic [CW-1:0] cw,
   output logic [DW-1:0] data,
   output logic          corrected
);

   localparam int SW = $clog2(CW+1);

   logic [SW-1:0] syn;
   logic [CW-1:0] fixed;

   always_comb begin
      syn = '0;
      for (int p = 1; p <= CW; p++) begin
         if (cw[CW-p]) syn = syn ^ SW'(p);
      end
   end

   always_comb begin
      fixed = cw;
      for (int p = 1; p <= CW; p++) begin
         if (syn == SW'(p)) fixed[CW-p] = ~cw[CW-p];
      end
   end

   // Shift in non-parity positions in ascending order: first lands at MSB.
   always_comb begin
      data = '0;
      for (int p = 1; p <= CW; p++) begin
         if ((p & (p - 1)) != 0) data = {data[DW-2:0], fixed[CW-p]};
      end
   end

   assign corrected = (syn != '0);

endmodule

// File: rtl/mdc_in_frontend.sv
// MDC input front end: decodes, buffers and hands off one matrix frame.
// Define MDC_FE_ERRCNT_EN to report per-frame corrected codeword count.
module mdc_in_frontend
   import mdc_pkg::*;
(
   input logic            clk,
   input logic            rst,
   mdc_in_frontend_if.slave bus
);

   fe_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [DW-1:0]    mem_q [N_WORDS];
   frm_size_t        size_q;
   logic             ovf_q;

   logic [DW-1:0]    d_dat;
   logic [MD_W-1:0]  m_dat;
   logic             d_corr, m_corr;
   logic             wr, start, last, set_ovf, hold;
   logic [CNT_W-1:0] wr_idx;

   mdc_hamming_dec #(.CW(CW_W), .DW(DW)) u_dec_d (
      .cw        (bus.in_data),
      .data      (d_dat),
      .corrected (d_corr)
   );

   mdc_hamming_dec #(.CW(MW_W), .DW(MD_W)) u_dec_m (
      .cw        (bus.in_mode),
      .data      (m_dat),
      .corrected (m_corr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      wr      = 1'b0;
      start   = 1'b0;
      last    = 1'b0;
      set_ovf = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               wr      = 1'b1;
               start   = 1'b1;
               state_d = FILL;
            end
         end
         FILL: begin
            if (bus.in_valid) begin
               wr = 1'b1;
               if (cnt_q == CNT_W'(N_WORDS-1)) begin
                  last    = 1'b1;
                  state_d = HOLD;
               end
            end else begin
               set_ovf = 1'b1;
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (bus.frm_ready && bus.in_valid) begin
               wr      = 1'b1;
               start   = 1'b1;
               state_d = FILL;
            end else if (bus.frm_ready) begin
               state_d = IDLE;
            end else if (bus.in_valid) begin
               set_ovf = 1'b1;
               state_d = DROP;
            end
         end
         DROP: begin
            if (!bus.in_valid) state_d = HOLD;
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr_idx = start ? '0 : cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         size_q <= SZ_ILL;
         ovf_q  <= 1'b0;
         for (int i = 0; i < N_WORDS; i++) mem_q[i] <= '0;
      end else begin
         if (set_ovf) ovf_q <= 1'b1;
         if (set_ovf) begin
            cnt_q <= '0;
         end else if (wr) begin
            cnt_q <= start ? CNT_W'(1) : cnt_q + CNT_W'(1);
         end
         if (wr) mem_q[wr_idx] <= d_dat;
         if (start) size_q <= mode_to_size(m_dat);
      end
   end

   assign hold          = (state_q == HOLD);
   assign bus.frm_valid = hold;
   assign bus.frm_size  = hold ? size_q : SZ_ILL;
   assign bus.ovf       = ovf_q;

   always_comb begin
      bus.frm_data = '0;
      if (hold) begin
         for (int i = 0; i < N_WORDS; i++) bus.frm_data[DW*i +: DW] = mem_q[i];
      end
   end

`ifdef MDC_FE_ERRCNT_EN
   logic [EC_W-1:0] run_q, err_q;

   // Running count restarts with word 0, which also carries the mode word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q <= '0;
         err_q <= '0;
      end else if (wr) begin
         if (start) run_q <= EC_W'(d_corr) + EC_W'(m_corr);
         else       run_q <= run_q + EC_W'(d_corr);
         if (last)  err_q <= run_q + EC_W'(d_corr);
      end
   end

   assign bus.err_cnt = hold ? err_q : '0;
`else
   logic unused_corr;
   assign unused_corr = d_corr ^ m_corr ^ last;
   assign bus.err_cnt = '0;
`endif

endmodule
